// File: rtl/dm_cache_mem_responder.sv
// Line-granular backing store that answers dm_cache_fsm read/write-back requests, one at a time.
// Ready pulses LATENCY cycles after acceptance; the request is captured, so later input changes are ignored.
module dm_cache_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req_valid,
  input  logic         mem_req_rw,
  input  logic [31:0]  mem_req_addr,
  input  logic [255:0] mem_req_data,
  output logic [255:0] mem_data_data,
  output logic         mem_data_ready,
  output logic         busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               accept;
  logic               rd_load;
  logic               wr_commit;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               cap_rw;
  logic [IDX_W-1:0]   cap_idx;
  logic [255:0]       cap_data;
  logic [255:0]       mem [DEPTH];
  logic               unused_addr_bits;

  // Word w of line i powers up holding its own low byte address.
  function automatic logic [255:0] init_pattern(input logic [IDX_W-1:0] idx);
    logic [255:0] p;
    p = '0;
    for (int w = 0; w < 8; w++) begin
      p[w*32 +: 32] = 32'({idx, 3'(w), 2'b00});
    end
    return p;
  endfunction

  assign req_idx          = mem_req_addr[5+IDX_W-1:5];
  assign unused_addr_bits = ^{mem_req_addr[31:5+IDX_W], mem_req_addr[4:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 8'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the response is entered on the accept edge, before the capture registers load.
  assign rd_idx    = accept ? req_idx : cap_idx;
  assign rd_load   = (state_nxt == RESP) && (accept ? !mem_req_rw : !cap_rw);
  assign wr_commit = (state == RESP) && cap_rw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_rw        <= 1'b0;
      cap_idx       <= '0;
      cap_data      <= '0;
      mem_data_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_rw   <= mem_req_rw;
        cap_idx  <= req_idx;
        cap_data <= mem_req_data;
      end
      if (rd_load) begin
        mem_data_data <= mem[rd_idx] ^ init_pattern(rd_idx);
      end
    end
  end

  // Lines are stored XOR their power-up pattern, so a zero-initialised array reads back as that pattern.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[cap_idx] <= cap_data ^ init_pattern(cap_idx);
    end
  end

  assign mem_data_ready = (state == RESP);
  assign busy           = (state != IDLE);

endmodule
